// File: rtl/cache_tag_ctrl.sv
// MSI cache tag controller: CPU lookups, snoop handling, and victim writeback
// against an external 8-set tag RAM with a one-cycle synchronous read.
module cache_tag_ctrl #(
    parameter int IWIDTH = 3,
    parameter int TWIDTH = 9,
    parameter int EWIDTH = 11
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     cpu_req,
    input  logic                     cpu_rw,
    input  logic [IWIDTH+TWIDTH-1:0] cpu_addr,
    output logic                     cpu_ack,
    output logic                     cpu_hit,
    output logic                     bus_req,
    output logic [2:0]               bus_cmd,
    output logic [IWIDTH+TWIDTH-1:0] bus_addr,
    input  logic                     bus_done,
    input  logic                     snp_valid,
    input  logic [2:0]               snp_cmd,
    input  logic [IWIDTH+TWIDTH-1:0] snp_addr,
    output logic                     snp_ack,
    output logic                     snp_flush,
    output logic [IWIDTH-1:0]        tag_addr,
    output logic [EWIDTH-1:0]        tag_din,
    output logic                     tag_we,
    input  logic [EWIDTH-1:0]        tag_dout
);

    localparam int AWIDTH = IWIDTH + TWIDTH;

    localparam logic [2:0] IDLE        = 3'd0;
    localparam logic [2:0] LOOKUP      = 3'd1;
    localparam logic [2:0] COMPARE     = 3'd2;
    localparam logic [2:0] WB_WAIT     = 3'd3;
    localparam logic [2:0] FILL_WAIT   = 3'd4;
    localparam logic [2:0] UPD         = 3'd5;
    localparam logic [2:0] SNP_LOOKUP  = 3'd6;
    localparam logic [2:0] SNP_COMPARE = 3'd7;

    localparam logic [1:0] ST_I = 2'b00;
    localparam logic [1:0] ST_S = 2'b01;
    localparam logic [1:0] ST_M = 2'b10;

    localparam logic [2:0] CMD_RD   = 3'b001;
    localparam logic [2:0] CMD_RDX  = 3'b010;
    localparam logic [2:0] CMD_UPGR = 3'b011;
    localparam logic [2:0] CMD_WB   = 3'b100;

    logic [2:0]        state_q, state_d;
    logic [AWIDTH-1:0] addr_q, addr_d;
    logic              rw_q, rw_d;
    logic [2:0]        scmd_q, scmd_d;
    logic [1:0]        fstate_q, fstate_d;
    logic              snp_q, snp_d;
    logic              flush_q, flush_d;
    logic              cpu_ack_q, cpu_ack_d;
    logic              cpu_hit_q, cpu_hit_d;
    logic              snp_ack_q, snp_ack_d;
    logic              snp_flush_q, snp_flush_d;
    logic              bus_req_q, bus_req_d;
    logic [2:0]        bus_cmd_q, bus_cmd_d;
    logic [AWIDTH-1:0] bus_addr_q, bus_addr_d;
    logic              tag_we_q, tag_we_d;
    logic [EWIDTH-1:0] tag_din_q, tag_din_d;

    logic [1:0]        entry_st;
    logic [TWIDTH-1:0] entry_tag;
    logic [TWIDTH-1:0] req_tag;
    logic [IWIDTH-1:0] req_idx;
    logic              hit;
    logic [2:0]        fill_cmd;
    logic              snp_change;
    logic [1:0]        snp_new_st;
    logic              snp_new_flush;

    assign entry_st  = tag_dout[EWIDTH-1:TWIDTH];
    assign entry_tag = tag_dout[TWIDTH-1:0];
    assign req_tag   = addr_q[AWIDTH-1:IWIDTH];
    assign req_idx   = addr_q[IWIDTH-1:0];
    // Encoding 11 is neither S nor M, so it falls out as invalid here.
    assign hit       = ((entry_st == ST_S) || (entry_st == ST_M)) && (entry_tag == req_tag);
    assign fill_cmd  = rw_q ? CMD_RDX : CMD_RD;

    assign cpu_ack   = cpu_ack_q;
    assign cpu_hit   = cpu_hit_q;
    assign snp_ack   = snp_ack_q;
    assign snp_flush = snp_flush_q;
    assign bus_req   = bus_req_q;
    assign bus_cmd   = bus_cmd_q;
    assign bus_addr  = bus_addr_q;
    assign tag_we    = tag_we_q;
    assign tag_din   = tag_din_q;
    assign tag_addr  = (state_q != IDLE) ? req_idx : '0;

    always_comb begin
        snp_change    = 1'b0;
        snp_new_st    = entry_st;
        snp_new_flush = 1'b0;
        if (hit) begin
            case (scmd_q)
                CMD_RD: begin
                    if (entry_st == ST_M) begin
                        snp_change    = 1'b1;
                        snp_new_st    = ST_S;
                        snp_new_flush = 1'b1;
                    end
                end
                CMD_RDX, CMD_UPGR: begin
                    snp_change    = 1'b1;
                    snp_new_st    = ST_I;
                    snp_new_flush = (entry_st == ST_M);
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        rw_d        = rw_q;
        scmd_d      = scmd_q;
        fstate_d    = fstate_q;
        snp_d       = snp_q;
        flush_d     = flush_q;
        cpu_ack_d   = 1'b0;
        cpu_hit_d   = 1'b0;
        snp_ack_d   = 1'b0;
        snp_flush_d = 1'b0;
        bus_req_d   = bus_req_q;
        bus_cmd_d   = bus_cmd_q;
        bus_addr_d  = bus_addr_q;
        tag_we_d    = 1'b0;
        tag_din_d   = tag_din_q;

        case (state_q)
            IDLE: begin
                // Holding off while an ack is visible keeps a still-held request from re-entering.
                if (!cpu_ack_q && !snp_ack_q) begin
                    if (snp_valid) begin
                        addr_d  = snp_addr;
                        scmd_d  = snp_cmd;
                        snp_d   = 1'b1;
                        state_d = SNP_LOOKUP;
                    end else if (cpu_req) begin
                        addr_d  = cpu_addr;
                        rw_d    = cpu_rw;
                        snp_d   = 1'b0;
                        state_d = LOOKUP;
                    end
                end
            end
            LOOKUP:     state_d = COMPARE;
            SNP_LOOKUP: state_d = SNP_COMPARE;
            COMPARE: begin
                fstate_d = rw_q ? ST_M : ST_S;
                if (hit && (!rw_q || entry_st == ST_M)) begin
                    cpu_ack_d = 1'b1;
                    cpu_hit_d = 1'b1;
                    state_d   = IDLE;
                end else if (hit) begin
                    bus_req_d  = 1'b1;
                    bus_cmd_d  = CMD_UPGR;
                    bus_addr_d = addr_q;
                    state_d    = FILL_WAIT;
                end else if (entry_st == ST_M) begin
                    bus_req_d  = 1'b1;
                    bus_cmd_d  = CMD_WB;
                    bus_addr_d = {entry_tag, req_idx};
                    state_d    = WB_WAIT;
                end else begin
                    bus_req_d  = 1'b1;
                    bus_cmd_d  = fill_cmd;
                    bus_addr_d = addr_q;
                    state_d    = FILL_WAIT;
                end
            end
            WB_WAIT: begin
                // Drop the request for one cycle; FILL_WAIT re-raises it with the fill command.
                if (bus_done) begin
                    bus_req_d  = 1'b0;
                    bus_cmd_d  = fill_cmd;
                    bus_addr_d = addr_q;
                    state_d    = FILL_WAIT;
                end
            end
            FILL_WAIT: begin
                if (!bus_req_q) begin
                    bus_req_d = 1'b1;
                end else if (bus_done) begin
                    bus_req_d = 1'b0;
                    tag_we_d  = 1'b1;
                    tag_din_d = {fstate_q, req_tag};
                    state_d   = UPD;
                end
            end
            UPD: begin
                if (snp_q) begin
                    snp_ack_d   = 1'b1;
                    snp_flush_d = flush_q;
                end else begin
                    cpu_ack_d = 1'b1;
                end
                state_d = IDLE;
            end
            SNP_COMPARE: begin
                if (snp_change) begin
                    tag_we_d  = 1'b1;
                    tag_din_d = {snp_new_st, req_tag};
                    flush_d   = snp_new_flush;
                    state_d   = UPD;
                end else begin
                    snp_ack_d   = 1'b1;
                    snp_flush_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            rw_q        <= 1'b0;
            scmd_q      <= '0;
            fstate_q    <= ST_I;
            snp_q       <= 1'b0;
            flush_q     <= 1'b0;
            cpu_ack_q   <= 1'b0;
            cpu_hit_q   <= 1'b0;
            snp_ack_q   <= 1'b0;
            snp_flush_q <= 1'b0;
            bus_req_q   <= 1'b0;
            bus_cmd_q   <= '0;
            bus_addr_q  <= '0;
            tag_we_q    <= 1'b0;
            tag_din_q   <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            rw_q        <= rw_d;
            scmd_q      <= scmd_d;
            fstate_q    <= fstate_d;
            snp_q       <= snp_d;
            flush_q     <= flush_d;
            cpu_ack_q   <= cpu_ack_d;
            cpu_hit_q   <= cpu_hit_d;
            snp_ack_q   <= snp_ack_d;
            snp_flush_q <= snp_flush_d;
            bus_req_q   <= bus_req_d;
            bus_cmd_q   <= bus_cmd_d;
            bus_addr_q  <= bus_addr_d;
            tag_we_q    <= tag_we_d;
            tag_din_q   <= tag_din_d;
        end
    end

endmodule
